int_responder: RTL and testbench



---
 rtl/int_responder.sv | 146 ++++++++++++++
 tb/tb_int_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_responder.sv
// CPU-side interrupt responder: takes irq at instruction boundaries, acks, vectors and returns on reti.
// Optional build macro INT_RESP_COUNT_EN adds a 32-bit taken-interrupt counter readable at csr_sel=3.
module int_responder #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            irq,
    input  logic [PC_W-1:0] isr_addr,
    input  logic [1:0]      priority_select,
    input  logic            instr_boundary,
    input  logic [PC_W-1:0] next_pc,
    input  logic            ie_set,
    input  logic            ie_clr,
    input  logic            reti,
    input  logic [1:0]      csr_sel,
    output logic            iack,
    output logic            int_stall,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic            in_isr,
    output logic            ie,
    output logic [31:0]     csr_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACK  = 3'd1,
        JUMP = 3'd2,
        ISR  = 3'd3,
        RET  = 3'd4
    } state_t;

    state_t          state;
    logic [PC_W-1:0] epc;
    logic [PC_W-1:0] vec;
    logic [1:0]      cause;
    logic [31:0]     taken_count;
    logic [31:0]     epc_word;
    logic            take;

    // ie_clr retiring in the same cycle vetoes the take, so a disable is never overtaken.
    assign take = (state == IDLE) && irq && ie && instr_boundary && !ie_clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            iack        <= 1'b0;
            int_stall   <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            in_isr      <= 1'b0;
            ie          <= 1'b0;
            epc         <= '0;
            vec         <= '0;
            cause       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state     <= ACK;
                        iack      <= 1'b1;
                        int_stall <= 1'b1;
                        epc       <= next_pc;
                        vec       <= isr_addr;
                        cause     <= priority_select;
                        ie        <= 1'b0;
                    end else if (ie_clr) begin
                        ie <= 1'b0;
                    end else if (ie_set) begin
                        ie <= 1'b1;
                    end
                end
                ACK: begin
                    state       <= JUMP;
                    iack        <= 1'b0;
                    redirect    <= 1'b1;
                    redirect_pc <= vec;
                end
                JUMP: begin
                    state       <= ISR;
                    redirect    <= 1'b0;
                    redirect_pc <= '0;
                    int_stall   <= 1'b0;
                    in_isr      <= 1'b1;
                end
                ISR: begin
                    // No nesting: irq and ie_set are deliberately not looked at here.
                    if (reti) begin
                        state       <= RET;
                        in_isr      <= 1'b0;
                        redirect    <= 1'b1;
                        redirect_pc <= epc;
                        int_stall   <= 1'b1;
                    end
                end
                RET: begin
                    state       <= IDLE;
                    redirect    <= 1'b0;
                    redirect_pc <= '0;
                    int_stall   <= 1'b0;
                    ie          <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    iack        <= 1'b0;
                    redirect    <= 1'b0;
                    redirect_pc <= '0;
                    int_stall   <= 1'b0;
                    in_isr      <= 1'b0;
                end
            endcase
        end
    end

`ifdef INT_RESP_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taken_count <= '0;
        end else if (take) begin
            taken_count <= taken_count + 32'd1;
        end
    end
`else
    assign taken_count = '0;
`endif

    generate
        if (PC_W >= 32) begin : g_epc_trunc
            assign epc_word = epc[31:0];
        end else begin : g_epc_ext
            assign epc_word = {{(32-PC_W){1'b0}}, epc};
        end
    endgenerate

    always_comb begin
        csr_rdata = '0;
        case (csr_sel)
            2'd0:    csr_rdata = {29'b0, state == ISR, in_isr, ie};
            2'd1:    csr_rdata = epc_word;
            2'd2:    csr_rdata = {30'b0, cause};
            default: csr_rdata = taken_count;
        endcase
    end

endmodule

// File: tb/tb_int_responder.sv
// Bench for int_responder: directed stimulus, expected iack/redirect events queued with their cycle,
// a negedge monitor pops and compares them; status is checked through csr_rdata and the outputs.
module tb_int_responder;

    localparam int PC_W = 32;
    localparam logic [1:0] EV_IACK  = 2'd1;
    localparam logic [1:0] EV_REDIR = 2'd2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            irq = 1'b0;
    logic [PC_W-1:0] isr_addr = '0;
    logic [1:0]      priority_select = '0;
    logic            instr_boundary = 1'b0;
    logic [PC_W-1:0] next_pc = '0;
    logic            ie_set = 1'b0;
    logic            ie_clr = 1'b0;
    logic            reti = 1'b0;
    logic [1:0]      csr_sel = '0;
    logic            iack;
    logic            int_stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            in_isr;
    logic            ie;
    logic [31:0]     csr_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_takes = 0;
    logic [49:0] exp_q[$];

    int_responder #(.PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .irq(irq), .isr_addr(isr_addr),
        .priority_select(priority_select), .instr_boundary(instr_boundary),
        .next_pc(next_pc), .ie_set(ie_set), .ie_clr(ie_clr), .reti(reti),
        .csr_sel(csr_sel), .iack(iack), .int_stall(int_stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .in_isr(in_isr), .ie(ie), .csr_rdata(csr_rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic sb_pop(input string name, input logic [49:0] got);
        logic [49:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event %h (nothing expected)", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", name, got, exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (iack)
                sb_pop("iack_event", {EV_IACK, 16'(cyc), 32'd0});
            if (redirect)
                sb_pop("redirect_event", {EV_REDIR, 16'(cyc), redirect_pc});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic read_csr(input string name, input logic [1:0] sel, input logic [31:0] exp);
        csr_sel = sel;
        #1;
        check(name, csr_rdata, exp);
    endtask

    task automatic idle_inputs();
        irq = 1'b0; instr_boundary = 1'b0; ie_set = 1'b0; ie_clr = 1'b0; reti = 1'b0;
    endtask

    task automatic pulse_ie_set();
        ie_set = 1'b1;
        @(negedge clk);
        ie_set = 1'b0;
    endtask

    // Called at a negedge while IDLE with ie=1; ends at a negedge inside the handler.
    task automatic take(input logic [31:0] addr, input logic [1:0] pri, input logic [31:0] pc);
        irq = 1'b1; isr_addr = addr; priority_select = pri; next_pc = pc; instr_boundary = 1'b1;
        exp_q.push_back({EV_IACK, 16'(cyc + 1), 32'd0});
        exp_q.push_back({EV_REDIR, 16'(cyc + 2), addr});
        @(negedge clk);
        // Controller drops the source and presents a different vector after the ack.
        irq = 1'b0; isr_addr = 32'hdead_beef; priority_select = ~pri;
        next_pc = 32'hffff_fff0; instr_boundary = 1'b0;
        check("ack_stall", int_stall, 1);
        check("ack_ie", ie, 0);
        @(negedge clk);
        check("jump_stall", int_stall, 1);
        @(negedge clk);
        n_takes++;
        check("isr_in_isr", in_isr, 1);
        check("isr_stall", int_stall, 0);
        read_csr("isr_csr0", 2'd0, 32'd6);
        read_csr("isr_epc", 2'd1, pc);
        read_csr("isr_cause", 2'd2, {30'b0, pri});
    endtask

    // Called at a negedge in ISR with irq low; ends at a negedge in IDLE.
    task automatic ret_from_isr(input logic [31:0] pc);
        reti = 1'b1;
        exp_q.push_back({EV_REDIR, 16'(cyc + 1), pc});
        @(negedge clk);
        reti = 1'b0;
        check("ret_stall", int_stall, 1);
        @(negedge clk);
        check("ret_ie", ie, 1);
        read_csr("ret_csr0", 2'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        logic [31:0] exp_count;

        idle_inputs();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_iack", iack, 0);
        check("rst_redirect", redirect, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_ie", ie, 0);
        for (int s = 0; s < 4; s++)
            read_csr($sformatf("rst_csr%0d", s), 2'(s), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Masked by ie=0, then by instr_boundary=0
        irq = 1'b1; instr_boundary = 1'b1; isr_addr = 32'h100; next_pc = 32'h10;
        repeat (10) @(negedge clk);
        read_csr("masked_ie_csr0", 2'd0, 32'd0);
        instr_boundary = 1'b0;
        pulse_ie_set();
        check("ie_after_set", ie, 1);
        repeat (10) @(negedge clk);
        read_csr("masked_bnd_csr0", 2'd0, 32'd1);
        irq = 1'b0;
        @(negedge clk);

        // Basic take
        take(32'h0000_0200, 2'd2, 32'h0000_0040);

        // irq and ie_set in ISR are ignored
        irq = 1'b1; instr_boundary = 1'b1; isr_addr = 32'h500;
        ie_set = 1'b1;
        repeat (5) @(negedge clk);
        ie_set = 1'b0;
        check("isr_ie_hold", ie, 0);
        read_csr("isr_ignore_csr0", 2'd0, 32'd6);

        // Return with irq still high: retake two cycles after the reti edge
        isr_addr = 32'h300; priority_select = 2'd1; next_pc = 32'h80;
        reti = 1'b1;
        k = cyc;
        exp_q.push_back({EV_REDIR, 16'(k + 1), 32'h40});
        exp_q.push_back({EV_IACK, 16'(k + 3), 32'd0});
        exp_q.push_back({EV_REDIR, 16'(k + 4), 32'h300});
        @(negedge clk);
        reti = 1'b0;
        @(negedge clk);
        check("retake_ie", ie, 1);
        @(negedge clk);
        irq = 1'b0; instr_boundary = 1'b0; isr_addr = 32'hdead_beef; priority_select = 2'd3;
        repeat (2) @(negedge clk);
        n_takes++;
        read_csr("retake_epc", 2'd1, 32'h80);
        read_csr("retake_cause", 2'd2, 32'd1);
        ret_from_isr(32'h80);

        // ie_clr with irq: no take, ie cleared
        irq = 1'b1; instr_boundary = 1'b1; ie_clr = 1'b1; isr_addr = 32'h700;
        @(negedge clk);
        idle_inputs();
        check("clr_ie", ie, 0);
        read_csr("clr_csr0", 2'd0, 32'd0);
        pulse_ie_set();
        ie_set = 1'b1; ie_clr = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("set_clr_ie", ie, 0);

        // reti in IDLE: no redirect
        reti = 1'b1;
        repeat (2) @(negedge clk);
        reti = 1'b0;
        check("idle_reti_redirect", redirect, 0);
        check("idle_reti_pc", redirect_pc, 0);
        read_csr("idle_reti_csr0", 2'd0, 32'd0);

        // Third take/return, then counter
        pulse_ie_set();
        take(32'h0000_0a00, 2'd0, 32'h0000_1234);
        ret_from_isr(32'h0000_1234);
`ifdef INT_RESP_COUNT_EN
        exp_count = 32'(n_takes);
`else
        exp_count = 32'd0;
`endif
        read_csr("taken_count", 2'd3, exp_count);

        // Reset during ACK aborts the sequence
        irq = 1'b1; instr_boundary = 1'b1; isr_addr = 32'h900; priority_select = 2'd3; next_pc = 32'h44;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        idle_inputs();
        exp_q.delete();
        check("rstmid_iack", iack, 0);
        check("rstmid_stall", int_stall, 0);
        check("rstmid_ie", ie, 0);
        read_csr("rstmid_csr0", 2'd0, 32'd0);
        read_csr("rstmid_epc", 2'd1, 32'd0);
        read_csr("rstmid_count", 2'd3, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rstmid_redirect", redirect, 0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
